// File: rtl/tone_decoder.sv
// Locks onto one of 12 keys by timing full periods of tone_in; TONE_DECODER_GLITCH_FILTER_EN adds a 3-sample majority filter.
// Latency: outputs change one cycle after the deciding edge is seen (edge seen 2 cycles after tone_in, +2 with the filter).
// No backpressure: outputs are status levels plus a one-cycle strobe.
module tone_decoder #(
    parameter int TOL     = 16,
    parameter int MATCH_N = 2,
    parameter int TIMEOUT = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tone_in,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [11:0] key_onehot,
    output logic        key_strobe,
    output logic [13:0] period
);

    localparam logic [13:0] CNT_MAX = 14'(TIMEOUT - 1);
    localparam logic [13:0] TOL_W   = 14'(TOL);
    localparam int          MCW     = $clog2(MATCH_N + 1);

    localparam logic [13:0] KEY_PERIOD [12] = '{
        14'd3032, 14'd7644, 14'd6810, 14'd6066, 14'd5726, 14'd5102,
        14'd4544, 14'd4048, 14'd3822, 14'd3404, 14'd3600, 14'd3200
    };

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic             src_prev_q, src_prev_d;
    logic             edge_src, rise;
    logic [13:0]      cnt_q, cnt_d;
    logic [13:0]      period_q, period_d;
    logic             cand_vld_q, cand_vld_d;
    logic [3:0]       cand_q, cand_d;
    logic [MCW-1:0]   match_cnt_q, match_cnt_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic [11:0]      key_onehot_q, key_onehot_d;
    logic             key_strobe_q, key_strobe_d;
    logic             hit;
    logic [3:0]       hit_key;
    logic [13:0]      diff;

`ifdef TONE_DECODER_GLITCH_FILTER_EN
    logic hist1_q, hist1_d, hist2_q, hist2_d, filt_q, filt_d;
    assign edge_src = filt_q;
`else
    assign edge_src = sync2_q;
`endif

    always_comb begin
        sync1_d    = tone_in;
        sync2_d    = sync1_q;
        src_prev_d = edge_src;
`ifdef TONE_DECODER_GLITCH_FILTER_EN
        hist1_d = sync2_q;
        hist2_d = hist1_q;
        filt_d  = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
`endif
    end

    assign rise = edge_src & ~src_prev_q;

    // Tolerance windows never overlap at the default TOL; the lowest index wins otherwise.
    always_comb begin
        hit     = 1'b0;
        hit_key = '0;
        diff    = '0;
        for (int k = 0; k < 12; k++) begin
            diff = (cnt_q > KEY_PERIOD[k]) ? (cnt_q - KEY_PERIOD[k]) : (KEY_PERIOD[k] - cnt_q);
            if (!hit && (diff <= TOL_W)) begin
                hit     = 1'b1;
                hit_key = 4'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        cand_vld_d  = cand_vld_q;
        cand_d      = cand_q;
        match_cnt_d = match_cnt_q;
        key_code_d  = key_code_q;

        if (rise) begin
            cnt_d = 14'd1;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 14'd1;
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d     = ACQUIRE;
                    cand_vld_d  = 1'b0;
                    match_cnt_d = '0;
                end
            end
            ACQUIRE: begin
                if (rise) begin
                    period_d = cnt_q;
                    if (!hit) begin
                        cand_vld_d  = 1'b0;
                        match_cnt_d = '0;
                    end else if (cand_vld_q && (cand_q == hit_key)) begin
                        match_cnt_d = match_cnt_q + MCW'(1);
                    end else begin
                        cand_vld_d  = 1'b1;
                        cand_d      = hit_key;
                        match_cnt_d = MCW'(1);
                    end
                    if (hit && (match_cnt_d >= MCW'(MATCH_N))) begin
                        state_d    = LOCKED;
                        key_code_d = hit_key;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (rise) begin
                    period_d = cnt_q;
                    if (!hit || (hit_key != key_code_q)) begin
                        state_d     = ACQUIRE;
                        cand_vld_d  = hit;
                        cand_d      = hit_key;
                        match_cnt_d = hit ? MCW'(1) : '0;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        key_valid_d  = (state_d == LOCKED);
        key_strobe_d = key_valid_d && (state_q != LOCKED);
        key_onehot_d = key_valid_d ? (12'd1 << key_code_d) : 12'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            src_prev_q   <= 1'b0;
            cnt_q        <= '0;
            period_q     <= '0;
            cand_vld_q   <= 1'b0;
            cand_q       <= '0;
            match_cnt_q  <= '0;
            key_valid_q  <= 1'b0;
            key_code_q   <= '0;
            key_onehot_q <= '0;
            key_strobe_q <= 1'b0;
`ifdef TONE_DECODER_GLITCH_FILTER_EN
            hist1_q      <= 1'b0;
            hist2_q      <= 1'b0;
            filt_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            src_prev_q   <= src_prev_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            cand_vld_q   <= cand_vld_d;
            cand_q       <= cand_d;
            match_cnt_q  <= match_cnt_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            key_onehot_q <= key_onehot_d;
            key_strobe_q <= key_strobe_d;
`ifdef TONE_DECODER_GLITCH_FILTER_EN
            hist1_q      <= hist1_d;
            hist2_q      <= hist2_d;
            filt_q       <= filt_d;
`endif
        end
    end

    assign key_valid  = key_valid_q;
    assign key_code   = key_code_q;
    assign key_onehot = key_onehot_q;
    assign key_strobe = key_strobe_q;
    assign period     = period_q;

endmodule
